// File: rtl/light_fader_controller.sv
// Lamp controller: fades brightness up on a request, holds full brightness for a
// while after the last request, then fades back down. Drives a registered PWM output.
module light_fader_controller #(
  parameter int HOLD_CYCLES = 1000,
  parameter int STEP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       auto_light,
  input  logic       manual_on,
  input  logic       manual_off,
  output logic       lamp_pwm,
  output logic [7:0] level,
  output logic [1:0] state
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_OFF      = 2'd0,
    S_FADE_IN  = 2'd1,
    S_ON       = 2'd2,
    S_FADE_OUT = 2'd3
  } state_t;

  state_t            cur_state, nxt_state;
  logic [7:0]        level_next;
  logic [STEP_W-1:0] step_cnt, step_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [7:0]        pwm_cnt;
  logic              req;
  logic              step_last;

  assign req       = (auto_light | manual_on) & ~manual_off;
  assign step_last = (step_cnt == STEP_LAST);
  assign state     = cur_state;

  always_comb begin
    nxt_state  = cur_state;
    level_next = level;
    hold_next  = hold_cnt;
    if (manual_off) begin
      nxt_state  = S_OFF;
      level_next = 8'd0;
    end else begin
      case (cur_state)
        S_OFF: begin
          level_next = 8'd0;
          if (req) nxt_state = S_FADE_IN;
        end
        // A direction change wins over a pending step, so level never jumps.
        S_FADE_IN: begin
          if (!req) begin
            nxt_state = S_FADE_OUT;
          end else if (step_last) begin
            if (level >= 8'd254) begin
              level_next = 8'd255;
              nxt_state  = S_ON;
              hold_next  = HOLD_LAST;
            end else begin
              level_next = level + 8'd1;
            end
          end
        end
        S_ON: begin
          level_next = 8'd255;
          if (req) begin
            hold_next = HOLD_LAST;
          end else if (hold_cnt == '0) begin
            nxt_state = S_FADE_OUT;
          end else begin
            hold_next = hold_cnt - HOLD_W'(1);
          end
        end
        S_FADE_OUT: begin
          if (req) begin
            nxt_state = S_FADE_IN;
          end else if (step_last) begin
            if (level <= 8'd1) begin
              level_next = 8'd0;
              nxt_state  = S_OFF;
            end else begin
              level_next = level - 8'd1;
            end
          end
        end
        default: begin
          nxt_state  = S_OFF;
          level_next = 8'd0;
        end
      endcase
    end

    // The step counter restarts on every state entry so each fade step is a full period.
    step_next = step_last ? '0 : step_cnt + STEP_W'(1);
    if (nxt_state != cur_state) step_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= S_OFF;
      level     <= 8'd0;
      step_cnt  <= '0;
      hold_cnt  <= '0;
      pwm_cnt   <= 8'd0;
      lamp_pwm  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      level     <= level_next;
      step_cnt  <= step_next;
      hold_cnt  <= hold_next;
      pwm_cnt   <= pwm_cnt + 8'd1;
      lamp_pwm  <= (level == 8'd255) | (pwm_cnt < level);
    end
  end

endmodule

// File: tb/tb_light_fader_controller.sv
// Bench for light_fader_controller: directed scenarios followed by randomized input
// runs, every cycle compared against a cycle-level behavioural model.
module tb_light_fader_controller;

  localparam int STEP = 2;
  localparam int HOLD = 5;
  localparam int LIM  = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       auto_light = 1'b0;
  logic       manual_on = 1'b0;
  logic       manual_off = 1'b0;
  logic       lamp_pwm;
  logic [7:0] level;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0..3, cycles since entering a fade, idle cycles in ON.
  int m_mode = 0, m_level = 0, m_since = 0, m_idle = 0, m_pwm = 0;
  int m_lamp = 0;

  light_fader_controller #(.HOLD_CYCLES(HOLD), .STEP_CYCLES(STEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .auto_light (auto_light),
    .manual_on  (manual_on),
    .manual_off (manual_off),
    .lamp_pwm   (lamp_pwm),
    .level      (level),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst_b, input bit r, input bit off);
    if (!rst_b) begin
      m_mode = 0; m_level = 0; m_since = 0; m_idle = 0; m_pwm = 0; m_lamp = 0;
    end else begin
      m_lamp = ((m_level == 255) || (m_pwm < m_level)) ? 1 : 0;
      m_pwm  = (m_pwm + 1) % 256;
      if (off) begin
        m_mode = 0; m_level = 0; m_since = 0;
      end else begin
        case (m_mode)
          0: if (r) begin m_mode = 1; m_since = 0; end
          1: if (!r) begin
               m_mode = 3; m_since = 0;
             end else begin
               m_since++;
               if (m_since % STEP == 0) begin
                 m_level = (m_level < 255) ? m_level + 1 : 255;
                 if (m_level == 255) begin m_mode = 2; m_idle = 0; end
               end
             end
          2: if (r) m_idle = 0;
             else begin
               m_idle++;
               if (m_idle == HOLD) begin m_mode = 3; m_since = 0; end
             end
          default: if (r) begin
               m_mode = 1; m_since = 0;
             end else begin
               m_since++;
               if (m_since % STEP == 0) begin
                 m_level = (m_level > 0) ? m_level - 1 : 0;
                 if (m_level == 0) m_mode = 0;
               end
             end
        endcase
      end
    end
  endtask

  // One clock: inputs are stable here, sampled by DUT and model alike, compared after the edge.
  task automatic tick();
    bit rst_b = rst_n;
    bit off   = manual_off;
    bit r     = (auto_light | manual_on) & ~manual_off;
    @(posedge clk);
    model_step(rst_b, r, off);
    #1;
    chk("state", 32'(state), 32'(m_mode));
    chk("level", 32'(level), 32'(m_level));
    chk("lamp_pwm", 32'(lamp_pwm), 32'(m_lamp));
  endtask

  initial begin
    int n;
    int g;

    // Reset held with a pending request.
    rst_n = 1'b0; auto_light = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_lamp", 32'(lamp_pwm), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("release_state", 32'(state), 32'd1);

    // Full fade in, hold, fade out.
    n = 0; g = 0;
    while (state == 2'd1 && g < LIM) begin n++; g++; tick(); end
    chk("fade_in_len", 32'(n), 32'(255 * STEP));
    chk("on_level", 32'(level), 32'd255);
    chk("on_state", 32'(state), 32'd2);
    auto_light = 1'b0;
    n = 0; g = 0;
    while (state == 2'd2 && g < LIM) begin n++; g++; tick(); end
    chk("on_len", 32'(n), 32'(HOLD));
    n = 0; g = 0;
    while (state == 2'd3 && g < LIM) begin n++; g++; tick(); end
    chk("fade_out_len", 32'(n), 32'(255 * STEP));
    chk("off_state", 32'(state), 32'd0);
    chk("off_level", 32'(level), 32'd0);

    // Re-request during fade out at level 100.
    auto_light = 1'b1;
    g = 0;
    while (state != 2'd2 && g < LIM) begin g++; tick(); end
    chk("reach_on", 32'(g < LIM), 32'd1);
    auto_light = 1'b0;
    g = 0;
    while (!(state == 2'd3 && level == 8'd100) && g < LIM) begin g++; tick(); end
    chk("reach_100", 32'(g < LIM), 32'd1);
    auto_light = 1'b1;
    tick();
    chk("refade_state", 32'(state), 32'd1);
    chk("refade_level", 32'(level), 32'd100);
    tick();
    chk("refade_hold", 32'(level), 32'd100);
    tick();
    chk("refade_rise", 32'(level), 32'd101);

    // Force-off in the middle of a fade in.
    manual_off = 1'b1;
    tick();
    manual_off = 1'b0;
    g = 0;
    while (!(state == 2'd1 && level == 8'd50) && g < LIM) begin g++; tick(); end
    chk("reach_50", 32'(g < LIM), 32'd1);
    manual_off = 1'b1;
    tick();
    chk("moff_state", 32'(state), 32'd0);
    chk("moff_level", 32'(level), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("moff_hold", 32'(state), 32'd0);
    end
    manual_off = 1'b0;
    tick();
    chk("moff_release", 32'(state), 32'd1);

    // Manual on: ON held indefinitely, then hold timeout after release.
    auto_light = 1'b0; manual_on = 1'b1;
    g = 0;
    while (state != 2'd2 && g < LIM) begin g++; tick(); end
    chk("mon_reach_on", 32'(g < LIM), 32'd1);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("mon_state", 32'(state), 32'd2);
      chk("mon_lamp", 32'(lamp_pwm), 32'd1);
    end
    manual_on = 1'b0;
    n = 0; g = 0;
    while (state == 2'd2 && g < LIM) begin n++; g++; tick(); end
    chk("mon_on_len", 32'(n), 32'(HOLD));
    chk("mon_fade_out", 32'(state), 32'd3);

    // Reset mid-fade: straight to off, no fade out.
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_lamp", 32'(lamp_pwm), 32'd0);
    rst_n = 1'b1;

    // Request together with force-off from OFF: nothing happens.
    auto_light = 1'b1; manual_off = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("both_state", 32'(state), 32'd0);
      chk("both_level", 32'(level), 32'd0);
      chk("both_lamp", 32'(lamp_pwm), 32'd0);
    end
    auto_light = 1'b0; manual_off = 1'b0;

    // Randomized runs of held input patterns.
    for (int seg = 0; seg < 120; seg++) begin
      int len;
      len        = int'($urandom_range(1, 300));
      auto_light = ($urandom_range(0, 1) == 1);
      manual_on  = ($urandom_range(0, 5) == 0);
      manual_off = ($urandom_range(0, 12) == 0);
      rst_n      = ($urandom_range(0, 30) != 0);
      if (!rst_n) len = int'($urandom_range(1, 3));
      for (int i = 0; i < len; i++) tick();
      rst_n = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_fader_controller.md
LIGHT_FADER_CONTROLLER -- requirements
Module: light_fader_controller

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1000, number of cycles the lamp stays at full brightness after the last active request (legal range >= 1).
REQ-002 SHALL have parameter STEP_CYCLES, default 4, number of cycles per one-step brightness change during a fade (legal range >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port auto_light  input  1  level request from the movement/dark detection logic (1 = movement in the dark).
REQ-006 SHALL have port manual_on  input  1  wall-switch force-on request, level.
REQ-007 SHALL have port manual_off  input  1  wall-switch force-off, level; overrides all other inputs.
REQ-008 SHALL have port lamp_pwm  output  1  registered lamp drive.
REQ-009 SHALL have port level  output  8  current brightness, 0..255.
REQ-010 SHALL have port state  output  2  FSM state: OFF=0, FADE_IN=1, ON=2, FADE_OUT=3.

Function
REQ-011 SHALL define req = (auto_light | manual_on) & ~manual_off, sampled each rising edge.
REQ-012 OFF: level=0; req=1 -> FADE_IN on the next edge; otherwise stay in OFF.
REQ-013 SHALL have a step counter cleared on every state entry, counting 0..STEP_CYCLES-1 and wrapping to 0.
REQ-014 FADE_IN: on the edge where the step counter = STEP_CYCLES-1, level increments by 1; the edge that makes level 255 also moves the FSM to ON; a full fade from 0 takes 255*STEP_CYCLES cycles.
REQ-015 FADE_IN with req=0 -> FADE_OUT on the next edge; level is kept, with no jump.
REQ-016 ON: level=255; hold counter loads HOLD_CYCLES-1 on entry and on every cycle with req=1.
REQ-017 ON with req=0: hold counter decrements; req=0 with hold counter=0 -> FADE_OUT; ON therefore lasts exactly HOLD_CYCLES cycles after the last req=1 cycle.
REQ-018 FADE_OUT: on the edge where the step counter = STEP_CYCLES-1, level decrements by 1; the edge that makes level 0 also moves the FSM to OFF.
REQ-019 FADE_OUT with req=1 -> FADE_IN on the next edge, rising from the current level.
REQ-020 manual_off=1 in any state: state=OFF and level=0 on the next edge; this takes priority over all other transitions and simultaneous events.
REQ-021 SHALL never let level wrap: no increment above 255, no decrement below 0.
REQ-022 SHALL have an 8-bit free-running PWM counter, cleared by reset.
REQ-023 lamp_pwm SHALL be registered as (level==255) | (pwm_cnt < level), giving one cycle of latency from level; level 0 -> constant 0, level 255 -> constant 1.
REQ-024 The state encoding on the state output SHALL be fixed as REQ-010 and SHALL be observable at all times.

Reset
REQ-025 With rst_n=0 at an edge: state=OFF, level=0, lamp_pwm=0, and the step, hold and PWM counters=0, regardless of the other inputs.
REQ-026 Reset asserted mid-fade or in ON SHALL give the values in REQ-025 on the next edge; there is no fade-out on reset.
REQ-027 On the first edge after rst_n rises with req=1: transition to FADE_IN.

Verification (STEP_CYCLES=2, HOLD_CYCLES=5)
REQ-028 rst_n=0 for 3 cycles with auto_light=1 -> state=0, level=0, lamp_pwm=0 throughout; on the first edge after release, state=1.
REQ-029 auto_light=1 until ON, then 0 -> FADE_IN for 510 cycles, level=255; state=2 for exactly 5 cycles after the last req; FADE_OUT for 510 cycles; then state=0 and level=0.
REQ-030 auto_light re-asserted in FADE_OUT at level=100 -> state=1 next edge, level rises 100->101 after 2 cycles, with no reset of level.
REQ-031 manual_off=1 at level=50 in FADE_IN with auto_light=1 -> state=0 and level=0 next edge; stays OFF while manual_off=1; after release, state=1 next edge.
REQ-032 manual_on=1, auto_light=0 -> ON held indefinitely with lamp_pwm constant 1; after manual_on drops, 5 ON cycles, then FADE_OUT.
REQ-033 auto_light=1 and manual_off=1 asserted together from OFF -> no state change; level 0 and lamp_pwm 0 held.
